// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S ADC receive deframer.
// The optional envelope/beat detector is enabled with `define I2S_RX_PEAK_EN.
package i2s_rx_pkg;

    localparam int I2S_DATA_W       = 16;
    localparam int PEAK_BEAT_HI     = 'h2000;
    localparam int PEAK_BEAT_LO     = 'h1000;
    localparam int PEAK_DECAY_SHIFT = 6;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SHIFT_L    = 2'd1,
        SHIFT_R    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings bclk/lrck/adc_data into the clk domain and produces a one-clk strobe
// on every rising edge of the synchronized bclk.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic bclk,
    input  logic lrck,
    input  logic adc_data,
    output logic lrck_sync,
    output logic data_sync,
    output logic bclk_rise
);

    logic [SYNC_STAGES-1:0] bclk_q;
    logic [SYNC_STAGES-1:0] lrck_q;
    logic [SYNC_STAGES-1:0] data_q;
    logic                   bclk_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_q    <= '0;
            lrck_q    <= '0;
            data_q    <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_q    <= {bclk_q[SYNC_STAGES-2:0], bclk};
            lrck_q    <= {lrck_q[SYNC_STAGES-2:0], lrck};
            data_q    <= {data_q[SYNC_STAGES-2:0], adc_data};
            bclk_prev <= bclk_q[SYNC_STAGES-1];
        end
    end

    // lrck/data are taken from the same stage as bclk so all three share one latency
    assign bclk_rise = bclk_q[SYNC_STAGES-1] & ~bclk_prev;
    assign lrck_sync = lrck_q[SYNC_STAGES-1];
    assign data_sync = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_deframer.sv
// Deframes the oversampled serial ADC stream into signed left/right sample pairs.
// Optional envelope follower and beat pulse when `I2S_RX_PEAK_EN is defined.
module i2s_rx_deframer
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic                 bclk,
    input  logic                 lrck,
    input  logic                 adc_data,
    output logic [DATA_W-1:0]    sample_left,
    output logic [DATA_W-1:0]    sample_right,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] frame_err,
    output logic [DATA_W-2:0]    peak_level,
    output logic                 beat,
    output rx_state_t            fsm_state
);

    // Handshake: a pair transfers on any clk edge where sample_valid && sample_ready;
    // while sample_valid && !sample_ready the pair and sample_valid hold steady.

    localparam int CNT_W = $clog2(DATA_W);

    logic                lrck_s;
    logic                data_s;
    logic                bclk_rise;

    rx_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] shift_q, shift_d;
    logic [2*DATA_W-1:0] shift_in;
    logic                last_bit;
    logic                frame_done;
    logic                trunc;
    logic                can_load;
    logic                load;

    i2s_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .lrck      (lrck),
        .adc_data  (adc_data),
        .lrck_sync (lrck_s),
        .data_sync (data_s),
        .bclk_rise (bclk_rise)
    );

    assign shift_in  = {shift_q[2*DATA_W-2:0], data_s};
    assign last_bit  = (cnt_q == CNT_W'(DATA_W - 1));
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT_FRAME;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        trunc      = 1'b0;
        if (!rx_en) begin
            state_d = WAIT_FRAME;
            cnt_d   = '0;
        end else if (bclk_rise) begin
            case (state_q)
                WAIT_FRAME: begin
                    if (lrck_s) begin
                        state_d = SHIFT_L;
                        cnt_d   = '0;
                    end
                end
                SHIFT_L, SHIFT_R: begin
                    if (lrck_s) begin
                        // A frame start mid-frame is itself a valid start: resync on it
                        trunc   = 1'b1;
                        state_d = SHIFT_L;
                        cnt_d   = '0;
                    end else begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 1'b1;
                        if (last_bit) begin
                            cnt_d = '0;
                            if (state_q == SHIFT_L) begin
                                state_d = SHIFT_R;
                            end else begin
                                state_d    = WAIT_FRAME;
                                frame_done = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = WAIT_FRAME;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign can_load = !sample_valid || sample_ready;
    assign load     = frame_done && can_load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= '0;
        end else begin
            if (load) begin
                sample_left  <= shift_in[2*DATA_W-1:DATA_W];
                sample_right <= shift_in[DATA_W-1:0];
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (frame_done && !can_load) begin
                overrun <= 1'b1;
            end
            if (trunc && (frame_err != '1)) begin
                frame_err <= frame_err + 1'b1;
            end
        end
    end

`ifdef I2S_RX_PEAK_EN
    localparam logic [DATA_W-2:0] BEAT_HI = (DATA_W-1)'(PEAK_BEAT_HI);
    localparam logic [DATA_W-2:0] BEAT_LO = (DATA_W-1)'(PEAK_BEAT_LO);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] mono;
    logic [DATA_W-1:0] mono_neg;
    logic [DATA_W-2:0] mag;
    logic [DATA_W-2:0] peak_nxt;
    logic              armed_q;

    always_comb begin
        sum      = {shift_in[2*DATA_W-1], shift_in[2*DATA_W-1:DATA_W]}
                 + {shift_in[DATA_W-1], shift_in[DATA_W-1:0]};
        // (L+R)>>>1 always fits back into DATA_W bits
        mono     = sum[DATA_W:1];
        mono_neg = ~mono + 1'b1;
        if (mono == {1'b1, {(DATA_W-1){1'b0}}}) begin
            mag = '1;
        end else if (mono[DATA_W-1]) begin
            mag = mono_neg[DATA_W-2:0];
        end else begin
            mag = mono[DATA_W-2:0];
        end
        if (mag > peak_level) begin
            peak_nxt = mag;
        end else begin
            peak_nxt = peak_level - (peak_level >> PEAK_DECAY_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            peak_level <= '0;
            beat       <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            beat <= 1'b0;
            if (load) begin
                peak_level <= peak_nxt;
                if (armed_q && (peak_nxt > BEAT_HI)) begin
                    beat    <= 1'b1;
                    armed_q <= 1'b0;
                end else if (!armed_q && (peak_nxt < BEAT_LO)) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end
`else
    assign peak_level = '0;
    assign beat       = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// Bench for i2s_rx_deframer: BFM drives bclk at clk/8, frames are an lrck slot
// followed by 32 data bits; expected pairs come from a transaction-level model.
module tb_i2s_rx_deframer;
    import i2s_rx_pkg::*;

    localparam int DATA_W    = 16;
    localparam int ERR_CNT_W = 8;
    localparam int EW        = 3 * DATA_W - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 rx_en = 1'b0;
    logic                 bclk = 1'b0;
    logic                 lrck = 1'b0;
    logic                 adc_data = 1'b0;
    logic                 sample_ready = 1'b0;
    logic [DATA_W-1:0]    sample_left;
    logic [DATA_W-1:0]    sample_right;
    logic                 sample_valid;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] frame_err;
    logic [DATA_W-2:0]    peak_level;
    logic                 beat;
    rx_state_t            fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];
    int model_err   = 0;
    int model_peak  = 0;
    int model_beats = 0;
    bit model_armed = 1'b1;
    int beat_seen   = 0;

    always #5 clk = ~clk;

    i2s_rx_deframer #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .bclk         (bclk),
        .lrck         (lrck),
        .adc_data     (adc_data),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .peak_level   (peak_level),
        .beat         (beat),
        .fsm_state    (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_load(input logic [15:0] l, input logic [15:0] r);
        int sl, sr, mono, mag;
        logic [14:0] pk;
        sl   = $signed(l);
        sr   = $signed(r);
        mono = (sl + sr) >>> 1;
        mag  = (mono < 0) ? -mono : mono;
        if (mag > 32767) mag = 32767;
`ifdef I2S_RX_PEAK_EN
        if (mag > model_peak) model_peak = mag;
        else model_peak = model_peak - (model_peak / 64);
        if (model_armed && model_peak > 'h2000) begin
            model_beats++;
            model_armed = 1'b0;
        end else if (!model_armed && model_peak < 'h1000) begin
            model_armed = 1'b1;
        end
`endif
        pk = model_peak[14:0];
        exp_q.push_back({l, r, pk});
    endfunction

    function automatic void model_trunc();
        if (model_err < 255) model_err++;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && sample_valid && sample_ready) begin
            check("pair_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("pair", {sample_left, sample_right, peak_level}, exp_q.pop_front());
            end
        end
        if (beat) beat_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic lr, input logic d);
        @(negedge clk);
        bclk = 1'b0; lrck = lr; adc_data = d;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    task automatic send_partial(input logic [15:0] l, input logic [15:0] r, input int nbits);
        logic [31:0] fr;
        fr = {l, r};
        drive_bit(1'b1, 1'b0);
        for (int i = 31; i > 31 - nbits; i--) drive_bit(1'b0, fr[i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_load);
        if (expect_load) model_load(l, r);
        send_partial(l, r, 32);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_valid_low"}, sample_valid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_left"}, sample_left, 0);
        check({tag, "_right"}, sample_right, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_peak"}, peak_level, 0);
        check({tag, "_beat"}, beat, 0);
        check({tag, "_state"}, fsm_state, WAIT_FRAME);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rl, rr;
        int beat_base;

        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        rx_en = 1'b1;
        sample_ready = 1'b1;
        idle_bits(2);

        // basic frame
        send_frame(16'h1234, 16'hABCD, 1'b1);
        wait_drain("basic");

        // back-pressure and overrun
        sample_ready = 1'b0;
        send_frame(16'h0001, 16'h1111, 1'b1);
        send_frame(16'h0002, 16'h2222, 1'b0);
        idle_bits(1);
        check("hold_valid", sample_valid, 1'b1);
        check("hold_left", sample_left, 16'h0001);
        check("hold_right", sample_right, 16'h1111);
        check("overrun_set", overrun, 1'b1);
        sample_ready = 1'b1;
        wait_drain("bp_accept");
        send_frame(16'h0003, 16'h3333, 1'b1);
        wait_drain("after_overrun");
        check("overrun_sticky", overrun, 1'b1);

        // truncated frame then resync on the interrupting start
        send_partial(16'hFFFF, 16'h0000, 10);
        model_trunc();
        send_frame(16'h5A5A, 16'hC3C3, 1'b1);
        wait_drain("resync");
        check("frame_err_one", frame_err, 1);
        for (int i = 0; i < 300; i++) begin
            send_partial($urandom, $urandom, (i < 10) ? $urandom_range(1, 31) : $urandom_range(1, 4));
            model_trunc();
        end
        send_frame(16'h7E7E, 16'h0101, 1'b1);
        wait_drain("after_trunc");
        check("frame_err_sat", frame_err, 8'hFF);
        check("frame_err_model", frame_err, model_err);

        // rx_en dropped mid right channel
        send_partial(16'h4444, 16'h5555, 21);
        rx_en = 1'b0;
        idle_bits(3);
        check("rxen_state", fsm_state, WAIT_FRAME);
        check("rxen_no_valid", sample_valid, 1'b0);
        check("rxen_frame_err", frame_err, model_err);
        rx_en = 1'b1;
        send_frame(16'h6666, 16'h7777, 1'b1);
        wait_drain("rxen_resume");

        // randomized frames with random idle gaps
        for (int i = 0; i < 24; i++) begin
            rl = $urandom;
            rr = $urandom;
            if (i == 3) begin rl = 16'h8000; rr = 16'h8000; end
            if (i == 7) begin rl = 16'h7FFF; rr = 16'h8000; end
            send_frame(rl, rr, 1'b1);
            idle_bits($urandom_range(0, 2));
        end
        wait_drain("random");
        check("random_frame_err", frame_err, model_err);

        // reset held low mid-frame with a pair pending
        sample_ready = 1'b0;
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        send_partial(16'h1357, 16'h2468, 10);
        reset = 1'b0;
        idle_bits(2);
        check_idle_outputs("mid_reset");
        exp_q.delete();
        model_err   = 0;
        model_peak  = 0;
        model_armed = 1'b1;
        reset = 1'b1;
        sample_ready = 1'b1;
        send_frame(16'h0123, 16'h0055, 1'b1);
        wait_drain("post_reset");

        // envelope and beat
        beat_base = beat_seen;
        send_frame(16'h4000, 16'h4000, 1'b1);
        wait_drain("peak_4000");
`ifdef I2S_RX_PEAK_EN
        check("peak_4000_level", peak_level, 15'h4000);
        check("beat_first", beat_seen - beat_base, 1);
        for (int k = 0; k < 200 && model_peak >= 'h1000; k++) send_frame(16'h0000, 16'h0000, 1'b1);
        wait_drain("decay");
        check("decay_below_lo", peak_level < 15'h1000, 1'b1);
        check("no_beat_decay", beat_seen - beat_base, 1);
        send_frame(16'h8000, 16'h8000, 1'b1);
        wait_drain("peak_8000");
        check("peak_sat_level", peak_level, 15'h7FFF);
        check("beat_second", beat_seen - beat_base, 2);
`else
        check("peak_tied_zero", peak_level, 0);
        check("beat_tied_zero", beat_seen - beat_base, 0);
`endif
        check("beat_total", beat_seen, model_beats);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
